// File: rtl/mdio_phy_responder_pkg.sv
// Shared types and constants for the Clause-22 MDIO PHY responder.
package mdio_phy_responder_pkg;

    localparam int unsigned REG_W    = 16;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned SPEED_W  = 3;
    localparam int unsigned BCNT_W   = 4;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [REG_W-1:0] REG0_RST = 16'h1140;
    localparam logic [REG_W-1:0] REG1_RST = 16'h796D;

    localparam logic [SPEED_W-1:0] SPEED_1000 = 3'b100;
    localparam logic [SPEED_W-1:0] SPEED_100  = 3'b010;
    localparam logic [SPEED_W-1:0] SPEED_10   = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_START,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } mdio_state_e;

    // Frame header fields collected MSB first from the wire.
    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] phyad;
        logic [ADDR_W-1:0] regad;
    } mdio_hdr_t;

    // Register 0 {bit6, bit13} to one-hot speed; the reserved 11 maps to 1000M.
    function automatic logic [SPEED_W-1:0] speed_decode(input logic [REG_W-1:0] r0);
        logic [SPEED_W-1:0] s;
        case ({r0[6], r0[13]})
            2'b01:   s = SPEED_100;
            2'b00:   s = SPEED_10;
            default: s = SPEED_1000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO management bus between MAC (master) and PHY responder (slave).
interface mdio_phy_responder_if;
    logic Mdc;
    logic Mdo;
    logic MdoEn;
    logic Mdi;
    logic MdiEn;

    modport master (output Mdc, output Mdo, output MdoEn, input Mdi, input MdiEn);
    modport slave  (input Mdc, input Mdo, input MdoEn, output Mdi, output MdiEn);
endinterface

// File: rtl/mdio_phy_responder_regfile.sv
// 32 x 16 PHY register file: read-only ID/status regs, soft reset via reg0 bit15, speed decode.
module mdio_phy_responder_regfile
    import mdio_phy_responder_pkg::*;
#(
    parameter logic [REG_W-1:0] PHY_ID1 = 16'h0141,
    parameter logic [REG_W-1:0] PHY_ID2 = 16'h0CC2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               link_up,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [REG_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [REG_W-1:0]   rd_data_c,
    output logic [SPEED_W-1:0] speed
);

    logic [REG_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= (i == 0) ? REG0_RST : '0;
            end
            speed <= speed_decode(REG0_RST);
        end else if (wr_en) begin
            if (wr_addr == '0 && wr_data[15]) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    mem_q[i] <= (i == 0) ? REG0_RST : '0;
                end
                speed <= speed_decode(REG0_RST);
            end else if (wr_addr == '0) begin
                mem_q[0] <= wr_data;
                speed    <= speed_decode(wr_data);
            end else if (wr_addr >= ADDR_W'(4)) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    // Registers 1..3 are served from constants; bit 2 of reg1 follows the live link.
    always_comb begin
        rd_data_c = mem_q[rd_addr];
        case (rd_addr)
            ADDR_W'(1): rd_data_c = {REG1_RST[15:3], link_up, REG1_RST[1:0]};
            ADDR_W'(2): rd_data_c = PHY_ID1;
            ADDR_W'(3): rd_data_c = PHY_ID2;
            default:    ;
        endcase
    end

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder: oversamples Mdc, decodes frames, serves the PHY register file.
module mdio_phy_responder
    import mdio_phy_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR     = 5'h01,
    parameter int unsigned       PREAMBLE_LEN = 32,
    parameter logic [REG_W-1:0]  PHY_ID1      = 16'h0141,
    parameter logic [REG_W-1:0]  PHY_ID2      = 16'h0CC2,
    parameter int unsigned       SYNC_STAGES  = 2
) (
    input  logic                 Clk_reg,
    input  logic                 Reset,
    mdio_phy_responder_if.slave  mdio,
    input  logic                 Link_up,
    output logic [SPEED_W-1:0]   Speed,
    output logic                 Wr_done
);

    localparam int unsigned CNT_W = $clog2(PREAMBLE_LEN + 1);

    logic [SYNC_STAGES:0]   mdc_sync;
    logic [SYNC_STAGES-1:0] mdo_sync;
    logic                   mdc_rise_c;
    logic                   mdo_bit_c;

    mdio_state_e      state_q,   state_nxt;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_nxt;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_nxt;
    mdio_hdr_t        hdr_q,     hdr_nxt;
    logic [REG_W-1:0] rd_sr_q,   rd_sr_nxt;
    logic [REG_W-1:0] wr_sr_q,   wr_sr_nxt;
    logic             mdi_q,     mdi_nxt;
    logic             mdien_q,   mdien_nxt;
    logic             wr_done_q, wr_done_nxt;

    logic              match_c;
    logic              reading_c;
    logic              wr_en_c;
    logic [REG_W-1:0]  wr_data_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [REG_W-1:0]  rd_data_c;

    // Extra Mdc stage gives the previous synchronized level for edge detection.
    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            mdc_sync <= '0;
            mdo_sync <= '1;
        end else begin
            mdc_sync <= {mdc_sync[SYNC_STAGES-1:0], mdio.Mdc};
            mdo_sync <= {mdo_sync[SYNC_STAGES-2:0], mdio.Mdo};
        end
    end

    assign mdc_rise_c = mdc_sync[SYNC_STAGES-1] & ~mdc_sync[SYNC_STAGES];
    assign mdo_bit_c  = mdo_sync[SYNC_STAGES-1];

    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            bit_cnt_q <= '0;
            hdr_q     <= '0;
            rd_sr_q   <= '0;
            wr_sr_q   <= '0;
            mdi_q     <= 1'b1;
            mdien_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            pre_cnt_q <= pre_cnt_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            hdr_q     <= hdr_nxt;
            rd_sr_q   <= rd_sr_nxt;
            wr_sr_q   <= wr_sr_nxt;
            mdi_q     <= mdi_nxt;
            mdien_q   <= mdien_nxt;
            wr_done_q <= wr_done_nxt;
        end
    end

    assign match_c   = (hdr_q.phyad == PHY_ADDR);
    assign reading_c = match_c && (hdr_q.op == OP_READ);
    assign wr_data_c = {wr_sr_q[REG_W-2:0], mdo_bit_c};
    assign rd_addr_c = {hdr_q.regad[ADDR_W-2:0], mdo_bit_c};

    // Frame decoder; every action happens on a detected Mdc rising edge.
    always_comb begin
        state_nxt   = state_q;
        pre_cnt_nxt = pre_cnt_q;
        bit_cnt_nxt = bit_cnt_q;
        hdr_nxt     = hdr_q;
        rd_sr_nxt   = rd_sr_q;
        wr_sr_nxt   = wr_sr_q;
        mdi_nxt     = mdi_q;
        mdien_nxt   = mdien_q;
        wr_done_nxt = 1'b0;
        wr_en_c     = 1'b0;

        if (mdc_rise_c) begin
            case (state_q)
                S_IDLE, S_PRE: begin
                    if (mdo_bit_c) begin
                        state_nxt = S_PRE;
                        if (pre_cnt_q != CNT_W'(PREAMBLE_LEN)) begin
                            pre_cnt_nxt = CNT_W'(pre_cnt_q + 1'b1);
                        end
                    end else begin
                        state_nxt   = (pre_cnt_q == CNT_W'(PREAMBLE_LEN)) ? S_START : S_IDLE;
                        pre_cnt_nxt = '0;
                    end
                end
                S_START: begin
                    bit_cnt_nxt = '0;
                    state_nxt   = mdo_bit_c ? S_OP : S_IDLE;
                end
                S_OP: begin
                    hdr_nxt.op  = {hdr_q.op[0], mdo_bit_c};
                    bit_cnt_nxt = BCNT_W'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == BCNT_W'(1)) begin
                        bit_cnt_nxt = '0;
                        if (hdr_nxt.op == OP_READ || hdr_nxt.op == OP_WRITE) begin
                            state_nxt = S_PHYAD;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_PHYAD: begin
                    hdr_nxt.phyad = {hdr_q.phyad[ADDR_W-2:0], mdo_bit_c};
                    bit_cnt_nxt   = BCNT_W'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == BCNT_W'(ADDR_W - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = S_REGAD;
                    end
                end
                S_REGAD: begin
                    hdr_nxt.regad = rd_addr_c;
                    bit_cnt_nxt   = BCNT_W'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == BCNT_W'(ADDR_W - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = S_TA;
                        rd_sr_nxt   = rd_data_c;
                    end
                end
                S_TA: begin
                    bit_cnt_nxt = BCNT_W'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == '0) begin
                        if (reading_c) begin
                            mdien_nxt = 1'b1;
                            mdi_nxt   = 1'b0;
                        end
                    end else begin
                        bit_cnt_nxt = '0;
                        state_nxt   = S_DATA;
                        if (reading_c) begin
                            mdi_nxt   = rd_sr_q[REG_W-1];
                            rd_sr_nxt = {rd_sr_q[REG_W-2:0], 1'b0};
                        end
                    end
                end
                S_DATA: begin
                    wr_sr_nxt   = wr_data_c;
                    bit_cnt_nxt = BCNT_W'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == BCNT_W'(REG_W - 1)) begin
                        state_nxt   = S_IDLE;
                        bit_cnt_nxt = '0;
                        pre_cnt_nxt = '0;
                        mdien_nxt   = 1'b0;
                        mdi_nxt     = 1'b1;
                        if (match_c && hdr_q.op == OP_WRITE) begin
                            wr_en_c     = 1'b1;
                            wr_done_nxt = 1'b1;
                        end
                    end else if (reading_c) begin
                        mdi_nxt   = rd_sr_q[REG_W-1];
                        rd_sr_nxt = {rd_sr_q[REG_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state_nxt   = S_IDLE;
                    pre_cnt_nxt = '0;
                end
            endcase
        end
    end

    mdio_phy_responder_regfile #(
        .PHY_ID1 (PHY_ID1),
        .PHY_ID2 (PHY_ID2)
    ) u_regfile (
        .clk       (Clk_reg),
        .rst       (Reset),
        .link_up   (Link_up),
        .wr_en     (wr_en_c),
        .wr_addr   (hdr_q.regad),
        .wr_data   (wr_data_c),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c),
        .speed     (Speed)
    );

    assign mdio.Mdi   = mdi_q;
    assign mdio.MdiEn = mdien_q;
    assign Wr_done    = wr_done_q;

endmodule
